// File: rtl/sr_pkg.sv
// Shared definitions for SR flip-flop drivers: sequencer states and S/R control codes.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // {S, R} codes; 2'b11 is forbidden and never produced.
  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_RST  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;

endpackage

// File: rtl/sr_excite.sv
// Maps a target Q bit and the current modelled Q to the minimal {S, R} code.
module sr_excite
  import sr_pkg::*;
(
  input  logic       target,
  input  logic       qm,
  output logic [1:0] code
);

  always_comb begin
    // NOTE: default first so every path assigns code and no latch is inferred.
    code = SR_HOLD;
    if (target && !qm)
      code = SR_SET;
    else if (!target && qm)
      code = SR_RST;
  end

endmodule

// File: rtl/sr_excite_seq.sv
// Replays a pattern word bit-serially as S/R excitation for an SR flip-flop
// and checks the read-back Q one cycle after each drive.
module sr_excite_seq
  import sr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LW    = $clog2(WIDTH + 1),
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pat_data,
  input  logic [LW-1:0]    pat_len,
  input  logic             pat_valid,
  output logic             pat_ready,
  output logic             S,
  output logic             R,
  input  logic             q_fb,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CW-1:0]    err_cnt
);

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [LW-1:0]    cnt;
  logic             qm;      // Q expected after the code currently on S/R
  logic [1:0]       sr;
  logic             arm;
  logic             exp_q;
  logic [1:0]       code;
  logic [LW-1:0]    len_c;
  logic             cmp_fail;

  sr_excite u_excite (
    .target (sh[0]),
    .qm     (qm),
    .code   (code)
  );

  always_comb begin
    len_c = pat_len;
    if (pat_len > LW'(WIDTH))
      len_c = LW'(WIDTH);
  end

  assign cmp_fail  = arm && (q_fb != exp_q);
  assign mismatch  = cmp_fail;
  assign S         = sr[1];
  assign R         = sr[0];
  assign pat_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DRAIN);

  // Compare stage: whatever was driven this cycle is checked against q_fb next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arm   <= 1'b0;
      exp_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      arm   <= (state == INIT) || (state == RUN);
      exp_q <= qm;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sh      <= '0;
      cnt     <= '0;
      qm      <= 1'b0;
      sr      <= SR_HOLD;
      err_cnt <= '0;
    end else begin
      if (cmp_fail && (err_cnt != '1))
        err_cnt <= err_cnt + 1'b1;

      unique case (state)
        IDLE: begin
          sr <= SR_HOLD;
          if (pat_valid) begin
            sh      <= pat_data;
            cnt     <= len_c;
            qm      <= 1'b0;
            sr      <= SR_RST;
            err_cnt <= '0;
            state   <= INIT;
          end
        end
        INIT, RUN: begin
          if (cnt != '0) begin
            sr    <= code;
            qm    <= sh[0];
            sh    <= sh >> 1;
            cnt   <= cnt - 1'b1;
            state <= RUN;
          end else begin
            sr    <= SR_HOLD;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          sr    <= SR_HOLD;
          state <= IDLE;
        end
        default: begin
          sr    <= SR_HOLD;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_excite_seq.sv
// Directed bench for sr_excite_seq driving behavioural SR flip-flop models.
module tb_sr_excite_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] pat_data = '0;
  logic [3:0] pat_len = '0;
  logic       pat_valid = 1'b0;
  logic       pat_ready, s, r, q_fb, busy, done, mismatch;
  logic [7:0] err_cnt;
  logic [1:0] mode = 2'd0;   // 0 ideal, 1 stuck-at-1, 2 inverted
  logic       q_ff;

  logic [7:0] sat_data = '0;
  logic [3:0] sat_len = '0;
  logic       sat_valid = 1'b0;
  logic       sat_ready, sat_s, sat_r, sat_q_fb, sat_busy, sat_done, sat_mismatch;
  logic [1:0] sat_err;
  logic       q_sat;

  int errors = 0;
  int checks = 0;
  int sr11_seen = 0;

  always #5 clk = ~clk;

  sr_excite_seq #(.WIDTH(8), .CW(8)) u_dut (
    .clk(clk), .reset(reset), .pat_data(pat_data), .pat_len(pat_len),
    .pat_valid(pat_valid), .pat_ready(pat_ready), .S(s), .R(r), .q_fb(q_fb),
    .busy(busy), .done(done), .mismatch(mismatch), .err_cnt(err_cnt)
  );

  sr_excite_seq #(.WIDTH(8), .CW(2)) u_sat (
    .clk(clk), .reset(reset), .pat_data(sat_data), .pat_len(sat_len),
    .pat_valid(sat_valid), .pat_ready(sat_ready), .S(sat_s), .R(sat_r),
    .q_fb(sat_q_fb), .busy(sat_busy), .done(sat_done), .mismatch(sat_mismatch),
    .err_cnt(sat_err)
  );

  // Ideal SR flip-flops fed by each sequencer.
  always @(posedge clk or negedge reset)
    if (!reset) q_ff <= 1'b0;
    else if (s) q_ff <= 1'b1;
    else if (r) q_ff <= 1'b0;

  always @(posedge clk or negedge reset)
    if (!reset) q_sat <= 1'b0;
    else if (sat_s) q_sat <= 1'b1;
    else if (sat_r) q_sat <= 1'b0;

  assign q_fb     = (mode == 2'd1) ? 1'b1 : (mode == 2'd2) ? ~q_ff : q_ff;
  assign sat_q_fb = ~q_sat;

  always @(negedge clk)
    if ((s && r) || (sat_s && sat_r)) sr11_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [7:0] d, input logic [3:0] l);
    @(negedge clk);
    check("ready_before_accept", pat_ready, 1);
    pat_data  = d;
    pat_len   = l;
    pat_valid = 1'b1;
    @(posedge clk);
    #1 pat_valid = 1'b0;
  endtask

  task automatic watch(input int ncyc, output int done_at, output int mism_n, output int busy_n);
    done_at = 0;
    mism_n  = 0;
    busy_n  = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (done && done_at == 0) done_at = k;
      mism_n += int'(mismatch);
      busy_n += int'(busy);
    end
  endtask

  logic [1:0] basic_sr [6] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
  logic [7:0] b2b_data [3] = '{8'h05, 8'h01, 8'h02};
  logic [3:0] b2b_len  [3] = '{4'd3, 4'd1, 4'd2};
  int         b2b_acc_exp [3] = '{0, 6, 10};
  int         b2b_dn_exp  [3] = '{5, 9, 14};

  initial begin
    int done_at, mism_n, busy_n, done_seen, na, nd, sat_m;
    int acc [3];
    int dn [3];
    bit took;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready", pat_ready, 1);
    check("rst_sr", {s, r}, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_err", err_cnt, 0);

    // Basic pattern 0110, len 4
    accept(8'b0000_0110, 4'd4);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("basic_sr_c%0d", k), {s, r}, basic_sr[k-1]);
      check($sformatf("basic_done_c%0d", k), done, (k == 6));
      check($sformatf("basic_busy_c%0d", k), busy, 1);
      check($sformatf("basic_ready_c%0d", k), pat_ready, 0);
    end
    @(negedge clk);
    check("basic_idle_busy", busy, 0);
    check("basic_idle_ready", pat_ready, 1);
    check("basic_err", err_cnt, 0);

    // Stuck-at-1 flip-flop: only the INIT compare fails
    mode = 2'd1;
    accept(8'hFF, 4'd8);
    watch(12, done_at, mism_n, busy_n);
    check("stuck_done_at", done_at, 10);
    check("stuck_busy_cycles", busy_n, 10);
    check("stuck_mismatch_pulses", mism_n, 1);
    check("stuck_err", err_cnt, 1);
    mode = 2'd0;

    // Init only
    accept(8'h5A, 4'd0);
    @(negedge clk);
    check("init_only_sr_c1", {s, r}, 2'b01);
    check("init_only_done_c1", done, 0);
    @(negedge clk);
    check("init_only_sr_c2", {s, r}, 2'b00);
    check("init_only_done_c2", done, 1);
    check("init_only_busy_c2", busy, 1);
    @(negedge clk);
    check("init_only_busy_c3", busy, 0);
    check("init_only_err", err_cnt, 0);

    // Length above WIDTH is clamped
    accept(8'hFF, 4'd12);
    watch(12, done_at, mism_n, busy_n);
    check("clamp_done_at", done_at, 10);
    check("clamp_busy_cycles", busy_n, 10);
    check("clamp_mismatch_pulses", mism_n, 0);

    // Abort mid-RUN while bit 3 is on S/R, with an inverted flip-flop
    mode = 2'd2;
    accept(8'hA5, 4'd8);
    repeat (5) @(negedge clk);
    check("abort_pre_err", err_cnt, 3);
    check("abort_pre_mismatch", mismatch, 1);
    reset = 1'b0;
    #1;
    check("abort_sr", {s, r}, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", pat_ready, 1);
    check("abort_err", err_cnt, 0);
    check("abort_mismatch", mismatch, 0);
    done_seen = int'(done);
    repeat (2) begin
      @(negedge clk);
      done_seen += int'(done);
    end
    check("abort_no_done", done_seen, 0);
    reset = 1'b1;
    mode  = 2'd0;
    accept(8'h0B, 4'd5);
    watch(10, done_at, mism_n, busy_n);
    check("post_abort_done_at", done_at, 7);
    check("post_abort_busy_cycles", busy_n, 7);
    check("post_abort_mismatch", mism_n, 0);
    check("post_abort_err", err_cnt, 0);

    // Back-to-back with pat_valid held high
    @(posedge clk);
    #1;
    pat_valid = 1'b1;
    pat_data  = b2b_data[0];
    pat_len   = b2b_len[0];
    na = 0;
    nd = 0;
    for (int c = 0; c < 40 && nd < 3; c++) begin
      @(negedge clk);
      took = 1'b0;
      if (done) begin dn[nd] = c; nd++; end
      if (pat_ready && pat_valid && na < 3) begin acc[na] = c; na++; took = 1'b1; end
      @(posedge clk);
      #1;
      if (took) begin
        if (na < 3) begin
          pat_data = b2b_data[na];
          pat_len  = b2b_len[na];
        end else begin
          pat_valid = 1'b0;
        end
      end
    end
    check("b2b_done_count", nd, 3);
    check("b2b_accept_count", na, 3);
    for (int i = 0; i < 3; i++) begin
      if (i < na) check($sformatf("b2b_accept%0d", i), acc[i], b2b_acc_exp[i]);
      if (i < nd) check($sformatf("b2b_done%0d", i), dn[i], b2b_dn_exp[i]);
    end
    check("b2b_err", err_cnt, 0);

    // Counter saturation on the CW=2 instance with an inverted flip-flop
    @(negedge clk);
    sat_data  = 8'b0001_0110;
    sat_len   = 4'd5;
    sat_valid = 1'b1;
    @(posedge clk);
    #1 sat_valid = 1'b0;
    sat_m = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      sat_m += int'(sat_mismatch);
    end
    check("sat_mismatch_pulses", sat_m, 6);
    check("sat_err", sat_err, 3);
    check("sat_idle", sat_busy, 0);

    check("never_sr_11", sr11_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "bench time limit");
  end

endmodule
